// File: rtl/sm_sum_normalizer.sv
// Two-stage normaliser for the sign-magnitude adder result: canonicalises -0,
// emits a two's-complement and a saturated operand-width sign-magnitude form.
module sm_sum_normalizer #(
  parameter int NUM   = 18,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM:0]     in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM:0]     out_tc,
  output logic [NUM-1:0]   out_sm,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic           sign;
    logic           big;
    logic [NUM-1:0] mag;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_q, s1_d;
  logic            s2_free, s1_load, s2_load;
  logic [NUM:0]    mag_ext, tc_d;
  logic [NUM-1:0]  sm_d;

  assign s2_free   = !vld_pipe[2] | out_ready;
  assign in_ready  = !vld_pipe[1] | s2_free;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = vld_pipe[1] & s2_free;
  assign out_valid = vld_pipe[2];

  // Anything above 2^(NUM-1)-1 is exactly "top magnitude bit set".
  always_comb begin
    s1_d.mag  = in_sum[NUM-1:0];
    s1_d.sign = in_sum[NUM] & (in_sum[NUM-1:0] != '0);
    s1_d.big  = in_sum[NUM-1];
  end

  assign mag_ext = {1'b0, s1_q.mag};
  assign tc_d    = s1_q.sign ? (~mag_ext + 1'b1) : mag_ext;
  assign sm_d    = s1_q.big ? {s1_q.sign, {(NUM-1){1'b1}}}
                            : {s1_q.sign, s1_q.mag[NUM-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      out_tc   <= '0;
      out_sm   <= '0;
      out_ovf  <= 1'b0;
    end else begin
      // Stage 1 empties whenever it can move on and nothing new arrives.
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s1_load)  s1_q        <= s1_d;
      if (s2_free)  vld_pipe[2] <= vld_pipe[1];
      if (s2_load) begin
        out_tc  <= tc_d;
        out_sm  <= sm_d;
        out_ovf <= s1_q.big;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_count <= '0;
    else if (ovf_clr)
      ovf_count <= '0;
    else if (out_valid && out_ready && out_ovf && (ovf_count != {CNT_W{1'b1}}))
      ovf_count <= ovf_count + 1'b1;
  end
endmodule

// File: tb/tb_sm_sum_normalizer.sv
// Directed bench for sm_sum_normalizer (NUM=18); a second instance with
// CNT_W=2 exercises counter saturation on the same stimulus.
module tb_sm_sum_normalizer;
  localparam int NUM = 18;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           ovf_clr = 1'b0;
  logic [NUM:0]   in_sum = '0;

  logic           in_ready, out_valid, out_ovf;
  logic [NUM:0]   out_tc;
  logic [NUM-1:0] out_sm;
  logic [7:0]     ovf_count;

  logic           in_ready2, out_valid2, out_ovf2;
  logic [NUM:0]   out_tc2;
  logic [NUM-1:0] out_sm2;
  logic [1:0]     ovf_count2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm_sum_normalizer #(.NUM(NUM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_tc(out_tc), .out_sm(out_sm), .out_ovf(out_ovf),
    .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  sm_sum_normalizer #(.NUM(NUM), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_sum(in_sum), .out_valid(out_valid2), .out_ready(out_ready),
    .out_tc(out_tc2), .out_sm(out_sm2), .out_ovf(out_ovf2),
    .ovf_count(ovf_count2), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer with out_ready=1: check latency, fields, then drain.
  task automatic one(input string tag, input logic [NUM:0] sum,
                     input logic [NUM:0] tc, input logic [NUM-1:0] sm,
                     input logic ovf, input int cnt);
    in_valid = 1'b1;
    in_sum   = sum;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_tc"},  out_tc, tc);
    chk({tag, "_sm"},  out_sm, sm);
    chk({tag, "_ovf"}, out_ovf, ovf);
    tick();
    chk({tag, "_drain"}, out_valid, 0);
    chk({tag, "_cnt"},   ovf_count, cnt);
  endtask

  logic [NUM:0]   vec [4];
  logic [NUM:0]   etc [4];
  logic [NUM-1:0] esm [4];
  logic           eov [4];

  initial begin
    int snd, rcv, acc, cyc;
    logic ir, ov, oo;
    logic [NUM:0]   tcv;
    logic [NUM-1:0] smv;

    vec[0] = 19'h00011; etc[0] = 19'h00011; esm[0] = 18'h00011; eov[0] = 1'b0;
    vec[1] = 19'h40022; etc[1] = 19'h7FFDE; esm[1] = 18'h20022; eov[1] = 1'b0;
    vec[2] = 19'h00033; etc[2] = 19'h00033; esm[2] = 18'h00033; eov[2] = 1'b0;
    vec[3] = 19'h20044; etc[3] = 19'h20044; esm[3] = 18'h1FFFF; eov[3] = 1'b1;

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tc", out_tc, 0);
    chk("rst_out_sm", out_sm, 0);
    chk("rst_ovf_count", ovf_count, 0);
    tick();

    one("pos",  19'h00005, 19'h00005, 18'h00005, 1'b0, 0);
    one("neg",  19'h40005, 19'h7FFFB, 18'h20005, 1'b0, 0);
    one("nz",   19'h40000, 19'h00000, 18'h00000, 1'b0, 0);
    one("sat1", 19'h20000, 19'h20000, 18'h1FFFF, 1'b1, 1);
    one("sat2", 19'h7FFFF, 19'h40001, 18'h3FFFF, 1'b1, 2);

    // Backpressure: 5 cycles with out_ready=0, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = vec[0];
    snd = 0; rcv = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ir = in_ready; ov = out_valid; smv = out_sm; tcv = out_tc;
      if (ov) begin
        chk("bp_hold_sm", smv, esm[0]);
        chk("bp_hold_tc", tcv, etc[0]);
      end
      @(posedge clk);
      if (in_valid && ir) snd++;
      #1;
      if (snd < 4) in_sum = vec[snd];
    end
    chk("bp_accepted", snd, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc = 0;
    while (rcv < 4 && cyc < 30) begin
      @(negedge clk);
      ir = in_ready; ov = out_valid; smv = out_sm; tcv = out_tc; oo = out_ovf;
      @(posedge clk);
      if (in_valid && ir) snd++;
      if (ov && out_ready) begin
        chk("bp_ord_tc", tcv, etc[rcv]);
        chk("bp_ord_sm", smv, esm[rcv]);
        chk("bp_ord_ovf", oo, eov[rcv]);
        rcv++;
      end
      #1;
      if (snd < 4) in_sum = vec[snd];
      else in_valid = 1'b0;
      cyc++;
    end
    chk("bp_delivered", rcv, 4);
    chk("bp_cnt", ovf_count, 3);
    tick();
    chk("bp_no_dup", out_valid, 0);

    // Counter saturation on the CNT_W=2 instance
    rst_n = 1'b0;
    #1;
    chk("rst2_cnt", ovf_count, 0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_sum = 19'h20000;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ir = in_ready;
      @(posedge clk);
      if (ir) acc++;
      #1;
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat_accepted", acc, 5);
    chk("sat_cnt8", ovf_count, 5);
    chk("sat_cnt2", ovf_count2, 3);

    // Clear racing an overflow handshake
    in_valid = 1'b1;
    in_sum = 19'h20000;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pre_vld", out_valid, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_cnt8", ovf_count, 0);
    chk("clr_cnt2", ovf_count2, 0);

    // Reset mid-stream
    in_valid = 1'b1;
    in_sum = 19'h3FFFF;
    tick(); tick(); tick();
    chk("mid_pre_cnt", ovf_count, 1);
    chk("mid_pre_vld", out_valid, 1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_cnt", ovf_count, 0);
    chk("mid_rst_cnt2", ovf_count2, 0);
    chk("mid_rst_tc", out_tc, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_stale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sm_sum_normalizer.md
Name: sm_sum_normalizer

Overview:
- Consumer-side companion to the sign-magnitude adder/subtractor. Accepts the adder's NUM+1-bit sign-magnitude result through a valid/ready handshake.
- Canonicalises negative zero and emits two forms of the result:
  - a NUM+1-bit two's-complement value;
  - a NUM-bit saturated sign-magnitude value, returning the result to operand width so it can feed the adder again.
- Counts saturation events for the datapath status register.
- Two-stage pipeline with full backpressure.

Parameters:
- NUM, 18, operand width of the adder; input sum is NUM+1 bits.
- CNT_W, 8, width of the saturation event counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_sum is valid.
- in_ready  output  1  block accepts in_sum this cycle.
- in_sum  input  NUM+1  sign-magnitude: bit NUM is the sign, bits NUM-1:0 are the magnitude.
- out_valid  output  1  output fields are valid.
- out_ready  input  1  downstream accepts the output.
- out_tc  output  NUM+1  two's-complement value of in_sum.
- out_sm  output  NUM  saturated sign-magnitude: bit NUM-1 is the sign, bits NUM-2:0 are the magnitude.
- out_ovf  output  1  out_sm was saturated.
- ovf_count  output  CNT_W  number of delivered outputs with out_ovf=1; saturating.
- ovf_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - s1_valid=0, s2_valid=0, out_valid=0.
  - All data registers and out_tc, out_sm, out_ovf = 0; ovf_count=0.
  - in_ready=1 as soon as rst_n=1.
  - Reset mid-operation discards in-flight data; no partial output.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - Output fields are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- Ready chain (combinational):
  - s2_free = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_free.
  - No combinational path from in_valid to out_valid.
- Stage 1, on input handshake:
  - mag = in_sum[NUM-1:0].
  - sign = in_sum[NUM] & (mag != 0), which canonicalises -0 to +0.
  - big = (mag > 2^(NUM-1) - 1).
  - Registers sign, mag and big; sets s1_valid.
  - Without a handshake, s1_valid clears when stage 2 takes the entry.
- Stage 2, loads when s1_valid & s2_free:
  - out_tc = sign ? (~{1'b0,mag} + 1) : {1'b0,mag}, computed modulo 2^(NUM+1). Every input is representable.
  - out_sm = big ? {sign, all-ones(NUM-1)} : {sign, mag[NUM-2:0]}.
  - out_ovf = big. The sign is preserved on saturation.
  - Sets out_valid = s2_valid.
- Latency and throughput:
  - 2 cycles from input handshake to out_valid with out_ready held 1.
  - Throughput 1 per cycle.
  - At most 2 entries in flight. Strict order; no drop, no duplication.
- ovf_count:
  - Increments on an output handshake with out_ovf=1.
  - Saturates at 2^CNT_W - 1; never wraps.
  - ovf_clr=1 forces 0 next cycle. Clear wins over a simultaneous increment.
- Simultaneous events:
  - Stage 2 drains while stage 1 refills in the same cycle without a bubble.
  - A new input is accepted in the same cycle the pipeline is full and out_ready=1.

Test Plan (NUM=18):
- Positive: in_sum=19'h00005 with out_ready=1 -> two cycles later out_valid=1, out_tc=19'h00005, out_sm=18'h00005, out_ovf=0.
- Negative: in_sum=19'h40005, i.e. -5 -> out_tc=19'h7FFFB, out_sm=18'h20005, out_ovf=0.
- Negative zero: in_sum=19'h40000 -> out_tc=19'h00000, out_sm=18'h00000, out_ovf=0.
- Saturation, ovf_count increments per delivered overflow, ending at 2:
  - in_sum=19'h20000 -> out_sm=18'h1FFFF, out_ovf=1, ovf_count=1.
  - in_sum=19'h7FFFF -> out_tc=19'h40001, out_sm=18'h3FFFF, out_ovf=1, ovf_count=2.
- Backpressure: stream 4 inputs with out_ready=0 for 5 cycles ->
  - exactly 2 accepted, then in_ready=0;
  - out_valid=1 with fields stable;
  - release out_ready -> all 4 delivered in order, none lost or repeated.
- Counter and reset, with CNT_W=2:
  - 5 overflow outputs -> ovf_count=3.
  - ovf_clr in the same cycle as an overflow handshake -> ovf_count=0.
  - rst_n pulse mid-stream -> out_valid=0 and ovf_count=0 immediately; no stale output after release.
